// File: rtl/mem_responder_pkg.sv
// mem_resp_pkg: shared definitions for the memory responder.
//   - default widths for address, data and access counters
//   - FSM state and bus operation enums
//   - decode_op(): maps the raw read/write strobes to a bus operation
package mem_resp_pkg;

    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_CNT_W  = 16;

    typedef enum logic {INIT, READY} mem_state_e;

    typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} mem_op_e;

    // {write,read} = 11 is the bus park state and must decode as idle,
    // never as a write.
    function automatic mem_op_e decode_op(input logic read, input logic write);
        case ({write, read})
            2'b10:   return OP_WRITE;
            2'b01:   return OP_READ;
            default: return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: read/write memory bus between a requester (master)
// and the memory responder (slave).
//   read, write    : strobes from the master
//   addr, data_in  : access address and write data
//   data_out       : registered read data from the slave
//   rd_valid       : one-cycle pulse, data_out updated
// With MEM_RESP_PARITY_EN defined the bus also carries parity_inject
// (master -> slave) and the sticky parity_err (slave -> master).
interface mem_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
`ifdef MEM_RESP_PARITY_EN
    logic              parity_inject;
    logic              parity_err;

    modport master (output read, write, addr, data_in, parity_inject,
                    input  data_out, rd_valid, parity_err);
    modport slave  (input  read, write, addr, data_in, parity_inject,
                    output data_out, rd_valid, parity_err);
`else
    modport master (output read, write, addr, data_in,
                    input  data_out, rd_valid);
    modport slave  (input  read, write, addr, data_in,
                    output data_out, rd_valid);
`endif
endinterface

// File: rtl/mem_responder_sat_counter.sv
// sat_counter: WIDTH-bit event counter that stops at its maximum value.
//   clk   : clock
//   rst   : synchronous active-high reset, clears count
//   inc   : count one event this cycle
//   count : current count, saturating at 2**WIDTH-1
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        count_d = inc ? sat_inc(count_q) : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the read/write bus.
// A DEPTH x DATA_W array is cleared by an INIT sweep after reset (one
// location per cycle); accesses arriving during the sweep are dropped and
// flagged. In READY, writes commit at the sampling edge and reads return
// registered data one edge later with a rd_valid pulse.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : mem_responder_if slave (read/write/addr/data_in/data_out/rd_valid)
//   init_busy : high while the clear sweep runs
//   wr_cnt    : accepted writes, saturating
//   rd_cnt    : accepted reads, saturating
//   drop_err  : sticky, an access arrived while init_busy
// Optional: MEM_RESP_PARITY_EN adds an even-parity bit per location, the
// parity_inject / parity_err bus signals and the sticky parity check.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = MEM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus,
    output logic             init_busy,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             drop_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [0:0] S_INIT  = INIT;
    localparam logic [0:0] S_READY = READY;

`ifdef MEM_RESP_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem_q [DEPTH];
    logic [0:0]        state_q,    state_d;
    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rd_valid_q, rd_valid_d;
    logic              drop_err_q, drop_err_d;
    mem_op_e           op;
    logic              do_wr;
    logic              do_rd;
    logic [MEM_W-1:0]  wr_word;

`ifdef MEM_RESP_PARITY_EN
    logic parity_err_q, parity_err_d;
    // Stored bit makes the word XOR to zero; inject flips it to plant an error.
    assign wr_word = {(^bus.data_in) ^ bus.parity_inject, bus.data_in};
`else
    assign wr_word = bus.data_in;
`endif

    always_comb begin
        op    = decode_op(bus.read, bus.write);
        do_wr = (state_q == S_READY) && (op == OP_WRITE);
        do_rd = (state_q == S_READY) && (op == OP_READ);

        state_d    = state_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        drop_err_d = drop_err_q;
`ifdef MEM_RESP_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        if (state_q == S_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) state_d = S_READY;
            if (op != OP_IDLE)     drop_err_d = 1'b1;
        end

        if (do_rd) begin
            data_out_d = mem_q[bus.addr][DATA_W-1:0];
            rd_valid_d = 1'b1;
`ifdef MEM_RESP_PARITY_EN
            if (^mem_q[bus.addr]) parity_err_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            ptr_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            drop_err_q <= 1'b0;
`ifdef MEM_RESP_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            drop_err_q <= drop_err_d;
`ifdef MEM_RESP_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Storage has no reset of its own: the sweep after every reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) mem_q[ptr_q]    <= '0;
            else if (do_wr)        mem_q[bus.addr] <= wr_word;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_wr),
        .count (wr_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_rd),
        .count (rd_cnt)
    );

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign init_busy    = (state_q == S_INIT);
    assign drop_err     = drop_err_q;
`ifdef MEM_RESP_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule
